iir_mac_datapath: RTL and testbench
===================================

Name: iir_mac_datapath

Overview:
Multiply-accumulate datapath for a time-multiplexed IIR filter engine. It combines three parts:
- a 32x16 sample RAM;
- a registered 16x16 signed multiplier, which multiplies the RAM read data by an externally supplied coefficient;
- a 34-bit signed accumulator with clear and enable.

A sequencer outside this block drives addresses, coefficients and control phases. A scaler outside this block consumes the accumulator sum.

Parameters:
- DATA_W, 16, width of samples and coefficients.
- ADDR_W, 5, RAM address width (32 words).
- PROD_W, 31, product width, which is 2*DATA_W-1.
- ACC_W, 34, accumulator width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  RAM write enable.
- wr_addr  in  5  RAM write address.
- wr_data  in  16  RAM write data.
- rd_addr  in  5  RAM read address.
- rd_data  out  16  RAM read data, also the multiplier x operand.
- coeff  in  16  signed coefficient, the multiplier y operand.
- enable_mult  in  1  multiplier load enable.
- mult_valid  out  1  enable_mult delayed by 1 cycle.
- product  out  31  registered signed product.
- clear_acc  in  1  accumulator clear.
- enable_acc  in  1  accumulator add enable.
- acc_valid  out  1  enable_acc delayed by 1 cycle.
- sum  out  34  accumulator value.

Behaviour:
- Reset: reset, synchronous, active-high; clock clock.
- Reset values: product=0, sum=0, mult_valid=0, acc_valid=0.
- RAM contents are not reset. They are undefined until written.
- RAM (ram32 function):
  - 32 words of 16 bits.
  - Write is synchronous on a rising edge when wr=1.
  - Read is asynchronous: rd_data = mem[rd_addr] combinationally.
  - Read and write to the same address: rd_data shows the old word until the write edge and the new word after it. There is no bypass.
- Multiplier (mult function):
  - On a rising edge with enable_mult=1, product <= bits [30:0] of the full signed 32-bit result of rd_data*coeff.
  - With enable_mult=0, product holds its value.
  - Latency is 1 cycle.
  - Only -32768*-32768 overflows the 31-bit result. It wraps to 0x40000000, which reads as -2^30. This is the required behaviour.
  - mult_valid <= enable_mult on every edge.
- Accumulator (acc function):
  - On each rising edge, the first matching rule applies:
    - clear_acc=1: sum <= 0.
    - enable_acc=1: sum <= sum + sign-extend(product, 34).
    - otherwise: sum holds.
  - clear_acc has priority over enable_acc.
  - Arithmetic is two's complement modulo 2^34, wrapping with no saturation.
  - acc_valid <= enable_acc on every edge.
- Reset has priority over all other inputs on the same edge. A reset in mid-sequence zeroes product and sum immediately, but the RAM is retained.
- Overall latency: RAM address at cycle N, product at N+1, contribution visible in sum at N+2.

Decomposition:
- Shared package: DATA_W, ADDR_W, PROD_W and ACC_W constants.
- Sub-modules: ram32 (the storage array) as one natural sub-module. Multiplier and accumulator logic are inline in the top module.

Test Plan:
- Reset check: after reset, product=0, sum=0 and both valids are 0. Then write mem[3]=0x0100, set rd_addr=3 and coeff=0x0200 with enable_mult=1 → next cycle product=0x0020000 and mult_valid=1.
- Sign handling: mem[5]=0xFFFF (-1), coeff=0x0001 → product=0x7FFFFFFF (-1 in 31 bits). With enable_acc=1 for 1 cycle from sum=0 → sum=0x3FFFFFFFF.
- Overflow corner: mem[0]=0x8000, coeff=0x8000 → product=0x40000000. Also enable_mult=0 while the operands change → product holds.
- Accumulation: product held at 0x20000, enable_acc=1 for 4 cycles → sum=0x80000. Assert clear_acc together with enable_acc → sum=0 next cycle.
- RAM: read-during-write at addr 7 (old 0x1111, new 0x2222) → rd_data=0x1111 before the edge and 0x2222 after it. Write all 32 addresses with 0x1000+addr and read them back; addr 31 must equal 0x101F.
- Mid-run reset: sum=0x80000 and product nonzero, pulse reset → both 0 on the next edge; the previously written mem[3] still reads 0x0100.

Source files
------------

// File: rtl/iir_mac_datapath_pkg.sv
// Shared widths for the IIR MAC datapath and a product-to-accumulator sign extension.
// Product width is DATA_W*2-1, so only the -32768*-32768 corner case overflows it.
package iir_mac_datapath_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int PROD_W = 2 * DATA_W - 1;
  localparam int ACC_W  = 34;
  localparam int DEPTH  = 1 << ADDR_W;

  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/iir_mac_datapath_ram32.sv
// 32x16 sample store: synchronous write, asynchronous read, with no write-to-read bypass.
// Latency: a read is combinational and a write lands on the clock edge. There is no backpressure.
module iir_mac_datapath_ram32
  import iir_mac_datapath_pkg::*;
(
  input  logic              clock,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/iir_mac_datapath.sv
// MAC datapath: RAM read feeds a registered signed multiplier, which feeds a wrapping 34-bit accumulator.
// Latency: address at N, product at N+1, sum at N+2. There is no backpressure; the sequencer paces every phase.
module iir_mac_datapath
  import iir_mac_datapath_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [DATA_W-1:0] coeff_i,
  input  logic              enable_mult_i,
  output logic              mult_valid_o,
  output logic [PROD_W-1:0] product_o,
  input  logic              clear_acc_i,
  input  logic              enable_acc_i,
  output logic              acc_valid_o,
  output logic [ACC_W-1:0]  sum_o
);

  logic [PROD_W-1:0] product_q, product_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              mult_valid_q, acc_valid_q;
  logic [PROD_W-1:0] x_ext, y_ext;

  iir_mac_datapath_ram32 u_ram (
    .clock     (clock),
    .wr_i      (wr_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  // A multiply done at PROD_W width keeps exactly the low 31 bits of the 32-bit result,
  // so -32768*-32768 wraps to 0x40000000.
  assign x_ext = {{(PROD_W - DATA_W){rd_data_o[DATA_W-1]}}, rd_data_o};
  assign y_ext = {{(PROD_W - DATA_W){coeff_i[DATA_W-1]}}, coeff_i};

  always_comb begin
    product_d = product_q;
    if (enable_mult_i) begin
      product_d = x_ext * y_ext;
    end

    sum_d = sum_q;
    if (clear_acc_i) begin
      sum_d = '0;
    end else if (enable_acc_i) begin
      sum_d = sum_q + sext_prod(product_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      product_q    <= '0;
      sum_q        <= '0;
      mult_valid_q <= 1'b0;
      acc_valid_q  <= 1'b0;
    end else begin
      product_q    <= product_d;
      sum_q        <= sum_d;
      mult_valid_q <= enable_mult_i;
      acc_valid_q  <= enable_acc_i;
    end
  end

  assign product_o    = product_q;
  assign sum_o        = sum_q;
  assign mult_valid_o = mult_valid_q;
  assign acc_valid_o  = acc_valid_q;

endmodule

// File: tb/tb_iir_mac_datapath.sv
// Directed bench for iir_mac_datapath. Expected values are worked out by hand from the
// RAM, multiplier and accumulator behaviour.
module tb_iir_mac_datapath;
  import iir_mac_datapath_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [DATA_W-1:0] coeff_i;
  logic              enable_mult_i;
  logic              mult_valid_o;
  logic [PROD_W-1:0] product_o;
  logic              clear_acc_i;
  logic              enable_acc_i;
  logic              acc_valid_o;
  logic [ACC_W-1:0]  sum_o;

  int checks = 0;
  int errors = 0;

  iir_mac_datapath dut (
    .clock         (clock),
    .reset         (reset),
    .wr_i          (wr_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .rd_addr_i     (rd_addr_i),
    .rd_data_o     (rd_data_o),
    .coeff_i       (coeff_i),
    .enable_mult_i (enable_mult_i),
    .mult_valid_o  (mult_valid_o),
    .product_o     (product_o),
    .clear_acc_i   (clear_acc_i),
    .enable_acc_i  (enable_acc_i),
    .acc_valid_o   (acc_valid_o),
    .sum_o         (sum_o)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 ns so that both sampling and driving happen away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ram_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_i      = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    tick();
    wr_i      = 1'b0;
  endtask

  task automatic mult_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] c);
    rd_addr_i     = a;
    coeff_i       = c;
    enable_mult_i = 1'b1;
    tick();
    enable_mult_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
    coeff_i = '0; enable_mult_i = 1'b0; clear_acc_i = 1'b0; enable_acc_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_product", 64'(product_o), 64'h0);
    check("rst_sum", 64'(sum_o), 64'h0);
    check("rst_mult_valid", 64'(mult_valid_o), 64'h0);
    check("rst_acc_valid", 64'(acc_valid_o), 64'h0);

    // First product: 0x0100 * 0x0200 = 0x20000
    ram_write(5'd3, 16'h0100);
    mult_load(5'd3, 16'h0200);
    check("first_product", 64'(product_o), 64'h20000);
    check("first_mult_valid", 64'(mult_valid_o), 64'h1);
    tick();
    check("mult_valid_drop", 64'(mult_valid_o), 64'h0);

    // Sign handling: -1 * 1 = -1, then accumulate it into sum = 0
    ram_write(5'd5, 16'hFFFF);
    mult_load(5'd5, 16'h0001);
    check("neg_product", 64'(product_o), 64'h7FFF_FFFF);
    enable_acc_i = 1'b1;
    tick();
    enable_acc_i = 1'b0;
    check("neg_sum", 64'(sum_o), 64'h3_FFFF_FFFF);
    check("acc_valid_high", 64'(acc_valid_o), 64'h1);
    tick();
    check("sum_hold", 64'(sum_o), 64'h3_FFFF_FFFF);
    check("acc_valid_low", 64'(acc_valid_o), 64'h0);

    // Overflow corner, then the product holds while the operands change
    ram_write(5'd0, 16'h8000);
    mult_load(5'd0, 16'h8000);
    check("ovf_product", 64'(product_o), 64'h4000_0000);
    rd_addr_i = 5'd3;
    coeff_i   = 16'h1234;
    tick();
    check("product_hold", 64'(product_o), 64'h4000_0000);

    // Clear, then four accumulations of 0x20000
    clear_acc_i = 1'b1;
    tick();
    clear_acc_i = 1'b0;
    check("clear_sum", 64'(sum_o), 64'h0);
    mult_load(5'd3, 16'h0200);
    enable_acc_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    enable_acc_i = 1'b0;
    check("acc4_sum", 64'(sum_o), 64'h80000);

    // A clear takes priority over an add on the same edge
    clear_acc_i  = 1'b1;
    enable_acc_i = 1'b1;
    tick();
    clear_acc_i  = 1'b0;
    enable_acc_i = 1'b0;
    check("clear_priority", 64'(sum_o), 64'h0);

    // Mid-run reset clears the state but keeps the RAM contents
    enable_acc_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    enable_acc_i = 1'b0;
    check("pre_reset_sum", 64'(sum_o), 64'h80000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_product", 64'(product_o), 64'h0);
    check("midrst_sum", 64'(sum_o), 64'h0);
    rd_addr_i = 5'd3;
    #1;
    check("midrst_ram_kept", 64'(rd_data_o), 64'h0100);

    // Read during write: the old word before the edge, the new word after it
    ram_write(5'd7, 16'h1111);
    wr_i      = 1'b1;
    wr_addr_i = 5'd7;
    wr_data_i = 16'h2222;
    rd_addr_i = 5'd7;
    #1;
    check("rdw_old", 64'(rd_data_o), 64'h1111);
    tick();
    wr_i = 1'b0;
    check("rdw_new", 64'(rd_data_o), 64'h2222);

    // Fill every address, then read each one back
    for (int a = 0; a < DEPTH; a++) ram_write(ADDR_W'(a), DATA_W'(16'h1000 + a));
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_i = ADDR_W'(a);
      #1;
      check($sformatf("fill_rd_%0d", a), 64'(rd_data_o), 64'h1000 + 64'(a));
    end
    rd_addr_i = 5'd31;
    #1;
    check("fill_last", 64'(rd_data_o), 64'h101F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
